// File: rtl/multi_debouncer.sv
// N-channel debouncer: 2-flop synchroniser, symmetric stable-count filter, rise/fall pulses.
// Optional auto-repeat pulses on held channels when DEBOUNCE_REPEAT_EN is defined.
module multi_debouncer #(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 10000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] noisy,
  output logic [NUM_CH-1:0] clean,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] rep
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [NUM_CH-1:0] s1;
  logic [NUM_CH-1:0] s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= noisy;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          clean_q;
    logic          rise_q;
    logic          fall_q;
    logic          flip;
    logic          clean_nxt;

    // The counter only advances while the sample disagrees with the clean level,
    // so any agreeing sample restarts the filter window.
    always_comb begin
      flip      = (s2[i] != clean_q) && (cnt == CNT_LAST);
      clean_nxt = flip ? s2[i] : clean_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        if ((s2[i] == clean_q) || flip) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        clean_q <= clean_nxt;
        rise_q  <= flip & s2[i];
        fall_q  <= flip & ~s2[i];
      end
    end

    assign clean[i] = clean_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [HW-1:0] H_DELAY = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] H_WRAP  = HW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          rep_q;

    // Past the initial delay the counter cycles DELAY..DELAY+PERIOD-1, so it
    // stays bounded no matter how long the button is held.
    always_comb begin
      hold_nxt = '0;
      if (clean_nxt) begin
        hold_nxt = (hold == H_WRAP) ? H_DELAY : hold + HW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold  <= '0;
        rep_q <= 1'b0;
      end else begin
        hold  <= hold_nxt;
        rep_q <= (hold_nxt == H_DELAY);
      end
    end

    assign rep[i] = rep_q;
`else
    assign rep[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Table-driven bench for multi_debouncer (NUM_CH=2, STABLE_CYCLES=4) plus a bounce sequence.
// Expected rep is derived from the expected clean levels when DEBOUNCE_REPEAT_EN is defined.
module tb_multi_debouncer;

  localparam int NCH = 2;
  localparam int SC  = 4;
  localparam int RD  = 8;
  localparam int RP  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] noisy;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] rep;

  multi_debouncer #(
    .NUM_CH       (NCH),
    .STABLE_CYCLES(SC),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .noisy(noisy),
    .clean(clean),
    .rise (rise),
    .fall (fall),
    .rep  (rep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] noisy;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [1:0] n, input logic [1:0] c,
                     input logic [1:0] ri, input logic [1:0] f);
    vec_t v;
    v.rst   = r;
    v.noisy = n;
    v.clean = c;
    v.rise  = ri;
    v.fall  = f;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int k, input logic r, input logic [1:0] n, input logic [1:0] c);
    repeat (k) add(r, n, c, 2'b00, 2'b00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int         h[NCH];
    logic [1:0] er;
    int         waited;
    bit         got;

    rst   = 1'b1;
    noisy = '0;
    foreach (h[c]) h[c] = 0;

    // reset with inputs high, then release: clean=11 six edges later
    add_n(3, 1'b1, 2'b11, 2'b00);
    add_n(5, 1'b0, 2'b11, 2'b00);
    add(1'b0, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    // both released
    add_n(5, 1'b0, 2'b00, 2'b11);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    // ch0 press, ch1 untouched
    add_n(5, 1'b0, 2'b01, 2'b00);
    add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00);
    add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
    // ch0 release
    add_n(5, 1'b0, 2'b00, 2'b01);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    // 3-cycle glitch rejected
    add_n(3, 1'b0, 2'b01, 2'b00);
    add_n(5, 1'b0, 2'b00, 2'b00);
    // two 3-cycle glitches separated by one low sample: not cumulative
    add_n(3, 1'b0, 2'b01, 2'b00);
    add_n(1, 1'b0, 2'b00, 2'b00);
    add_n(3, 1'b0, 2'b01, 2'b00);
    add_n(5, 1'b0, 2'b00, 2'b00);
    // exactly 4-cycle pulse is accepted, then filtered release
    add_n(4, 1'b0, 2'b01, 2'b00);
    add_n(1, 1'b0, 2'b00, 2'b00);
    add(1'b0, 2'b00, 2'b01, 2'b01, 2'b00);
    add_n(3, 1'b0, 2'b00, 2'b01);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    // simultaneous press
    add_n(5, 1'b0, 2'b11, 2'b00);
    add(1'b0, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    // reset mid-release: no fall pulse afterwards
    add_n(3, 1'b0, 2'b00, 2'b11);
    add_n(1, 1'b1, 2'b00, 2'b00);
    add_n(6, 1'b0, 2'b00, 2'b00);
    // long hold on ch1 (20 hold cycles) then release
    add_n(5, 1'b0, 2'b10, 2'b00);
    add(1'b0, 2'b10, 2'b10, 2'b10, 2'b00);
    add_n(14, 1'b0, 2'b10, 2'b10);
    add_n(5, 1'b0, 2'b00, 2'b10);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b10);
    add_n(4, 1'b0, 2'b00, 2'b00);

    for (int k = 0; k < vecs.size(); k++) begin
      rst   = vecs[k].rst;
      noisy = vecs[k].noisy;
      step();
      er = 2'b00;
`ifdef DEBOUNCE_REPEAT_EN
      for (int c = 0; c < NCH; c++) begin
        if (vecs[k].rst || !vecs[k].clean[c]) h[c] = 0;
        else h[c] = h[c] + 1;
        er[c] = (h[c] >= RD) && (((h[c] - RD) % RP) == 0);
      end
`endif
      check($sformatf("row%0d clean", k), clean, vecs[k].clean);
      check($sformatf("row%0d rise", k), rise, vecs[k].rise);
      check($sformatf("row%0d fall", k), fall, vecs[k].fall);
      check($sformatf("row%0d rep", k), rep, er);
      check($sformatf("row%0d rise_and_fall", k), rise & fall, 2'b00);
    end

    // bouncing press on ch1: count restarts after the last bounce
    rst   = 1'b0;
    noisy = 2'b10;
    step();
    step();
    noisy = 2'b00;
    step();
    noisy  = 2'b10;
    waited = 0;
    got    = 1'b0;
    for (int w = 1; w <= 30 && !got; w++) begin
      step();
      if (rise[1] === 1'b1) begin
        got    = 1'b1;
        waited = w;
      end
    end
    check_int("bounce rise latency", waited, 6);
    check("bounce clean", clean, 2'b10);
    step();
    check("bounce rise width", rise, 2'b00);
    check("bounce clean hold", clean, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised N-channel debouncer for push-buttons and switches. Generation after the single-channel press-only debouncer.
- Adds an input synchroniser, symmetric press/release filtering, one-cycle rise/fall event pulses and a synchronous reset.
- Sits between board pins and the game logic. Game FSMs consume the pulses directly instead of building their own edge detectors.

Parameters:
- NUM_CH, 4, number of independent input channels (>=1).
- STABLE_CYCLES, 10000, consecutive synchronised samples that must differ from the current clean value before it flips (>=1).
- REPEAT_DELAY, 500000, hold cycles before the first auto-repeat pulse (used only with DEBOUNCE_REPEAT_EN).
- REPEAT_PERIOD, 100000, cycles between subsequent auto-repeat pulses (used only with DEBOUNCE_REPEAT_EN).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- noisy  in  NUM_CH  raw asynchronous button/switch levels, bit i = channel i.
- clean  out  NUM_CH  debounced level per channel.
- rise  out  NUM_CH  one-cycle pulse when clean[i] goes 0->1.
- fall  out  NUM_CH  one-cycle pulse when clean[i] goes 1->0.
- rep  out  NUM_CH  auto-repeat pulses while held; constant 0 when the feature is compiled out.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: synchroniser flops, counters, clean, rise, fall and rep all 0. Reset takes effect at the first clk edge with rst=1, has priority over everything, and discards any count in progress.
- Synchroniser: per channel, 2-flop chain s1 <- noisy, s2 <- s1. s2 is the filtered sample. No combinational path from noisy to any output.
- Counter: per channel, width $clog2(STABLE_CYCLES+1). Each edge:
  - if s2 == clean: cnt <= 0.
  - else if cnt == STABLE_CYCLES-1: clean <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
- Latency: a clean level change on noisy appears on clean exactly 2+STABLE_CYCLES edges later.
- Glitch rejection: any excursion shorter than STABLE_CYCLES synchronised samples leaves clean unchanged and resets cnt to 0. Counting is not cumulative across glitches.
- Symmetry: press and release are filtered identically. This replaces the old instant-release behaviour.
- Event pulses:
  - rise[i] is registered, high for exactly the first cycle clean[i] reads 1.
  - fall[i] is likewise high for exactly the first cycle clean[i] reads 0.
  - rise and fall are never high together on one channel.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Counter never wraps: it saturates by construction at STABLE_CYCLES-1 and then clears.
- STABLE_CYCLES=1: clean follows s2 with one cycle of delay.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined:
  - Per channel, a hold counter runs while clean[i]=1. The rise cycle counts as hold cycle 1.
  - rep[i] pulses for one cycle when the hold count reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles while held.
  - The hold counter clears on clean[i]=0 or rst. A fall mid-period produces no further rep pulse.
  - rise itself is not duplicated onto rep.
- Not defined: rep is tied to 0 and no hold counters are synthesised.

Test Plan (NUM_CH=2, STABLE_CYCLES=4; repeat test REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Reset held 3 cycles with noisy=2'b11 -> clean, rise, fall, rep all 0 throughout; after release, clean=2'b11 exactly 6 edges later.
- noisy[0] 0->1 and held -> clean[0]=1 on edge 6; rise[0]=1 for that one cycle only; fall=0; channel 1 untouched.
- noisy[0] high for 3 cycles then low -> clean[0] stays 0, no rise pulse. Then 4 cycles high -> clean[0] rises.
- clean[0]=1, noisy[0] 1->0 -> clean[0]=0 on edge 6; fall[0] single-cycle pulse.
- noisy=2'b11 on the same edge -> rise=2'b11 in the same cycle. Then rst pulsed mid-release count -> clean=0, no fall pulse emitted.
- With DEBOUNCE_REPEAT_EN, hold ch1 for 20 cycles after rise -> rep[1] pulses at hold cycles 8, 11, 14, 17, 20. Release -> no further rep. Without the macro, rep stays 0.
